ram_blk_dp_ext: RTL and testbench

Parameterised dual-port block RAM with one write port and one read port, and the next-generation replacement for the plain dual-port RAM. It adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register with a valid flag, and a hardware clear sequencer that fills the array after reset. Used wherever FIFOs, line buffers and lookup tables need masked writes or a known initial state without a software fill.

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clear_seq.sv | 39 +++
 rtl/ram_blk_dp_ext.sv | 120 ++++++++++++
 tb/tb_ram_blk_dp_ext.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants and clear-sequencer state encoding for the block RAM
package ram_pkg;

    // Read-during-write selection values for RDW_MODE
    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset fill sequencer walking every address once
// Ports: clk, reset (async, active-high), busy (clear in progress),
//        clr_we (array write strobe), clr_addr (address being filled)
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDRWIDTH      = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 busy,
    output logic                 clr_we,
    output logic [ADDRWIDTH-1:0] clr_addr
);

    localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;

    clr_state_t           state;
    logic [ADDRWIDTH-1:0] cnt;

    // The counter simply wraps to zero on the final write and then idles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= ST_READY;
            end
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = busy;
    assign clr_addr = cnt;

endmodule

// File: rtl/ram_blk_dp_ext.sv
// rtl/ram_blk_dp_ext.sv - dual-port block RAM with byte enables, RDW mode, output reg and clear
// Ports: clk, reset (async, active-high)
//        write port: wr_data, wr_addr, we, wr_be (per-lane enables)
//        read port:  rd_addr, re -> rd_data (held), rd_valid (one-cycle pulse)
//        busy: clear sequence running, user accesses ignored
module ram_blk_dp_ext
    import ram_pkg::*;
#(
    parameter int                  DATAWIDTH      = 32,
    parameter int                  ADDRWIDTH      = 9,
    parameter int                  BYTEWIDTH      = 8,
    parameter int                  RDW_MODE       = 0,
    parameter int                  OUT_REG        = 0,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DATAWIDTH-1:0]           wr_data,
    input  logic [ADDRWIDTH-1:0]           wr_addr,
    input  logic                           we,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0] wr_be,
    input  logic [ADDRWIDTH-1:0]           rd_addr,
    input  logic                           re,
    output logic [DATAWIDTH-1:0]           rd_data,
    output logic                           rd_valid,
    output logic                           busy
);

    localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
    localparam int DEPTH  = 1 << ADDRWIDTH;
    localparam bit BYPASS = (RDW_MODE == RDW_NEW);

    logic                 clr_we;
    logic [ADDRWIDTH-1:0] clr_addr;

    ram_clear_seq #(
        .ADDRWIDTH      (ADDRWIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic                 user_wr;
    logic                 rd_acc;
    logic                 same_addr;
    logic [ADDRWIDTH-1:0] mem_addr;
    logic [DATAWIDTH-1:0] mem_data;
    logic [DATAWIDTH-1:0] rd_word;

    assign user_wr   = we && !busy && (|wr_be);
    assign rd_acc    = re && !busy;
    assign same_addr = (wr_addr == rd_addr);
    assign mem_addr  = busy ? clr_addr : wr_addr;
    assign mem_data  = busy ? CLEAR_VALUE : wr_data;

    // One storage array per lane so each lane has a single writer.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        logic [BYTEWIDTH-1:0] mem [DEPTH];
        logic                 lane_we;
        logic                 lane_bypass;

        assign lane_we     = busy ? clr_we : (user_wr && wr_be[g]);
        assign lane_bypass = BYPASS && user_wr && wr_be[g] && same_addr;

        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem[mem_addr] <= mem_data[g*BYTEWIDTH +: BYTEWIDTH];
            end
        end

        // Array read sees the pre-write word; bypass substitutes enabled new lanes.
        assign rd_word[g*BYTEWIDTH +: BYTEWIDTH] =
            lane_bypass ? wr_data[g*BYTEWIDTH +: BYTEWIDTH] : mem[rd_addr];
    end

    logic [DATAWIDTH-1:0] s1_data;
    logic                 s1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) begin
                s1_data <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATAWIDTH-1:0] s2_data;
        logic                 s2_valid;

        // Data advances only with its valid bit so the output holds between reads.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s2_data  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign rd_data  = s2_data;
        assign rd_valid = s2_valid;
    end else begin : g_no_out_reg
        assign rd_data  = s1_data;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_ram_blk_dp_ext.sv
// tb/tb_ram_blk_dp_ext.sv - directed self-checking bench for ram_blk_dp_ext
module tb_ram_blk_dp_ext;

    localparam logic [31:0] CV = 32'hA5A5A5A5;

    logic        clk;
    logic        reset;
    logic [31:0] wr_data;
    logic [3:0]  wr_addr;
    logic        we;
    logic [3:0]  wr_be;
    logic [3:0]  rd_addr;
    logic        re;

    // dut0: RDW old data, no output register; dut1: RDW bypass, output register
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int n_checks;
    int n_fail;

    ram_blk_dp_ext #(
        .DATAWIDTH(32), .ADDRWIDTH(4), .BYTEWIDTH(8), .RDW_MODE(0),
        .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut0 (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .we(we), .wr_be(wr_be), .rd_addr(rd_addr), .re(re),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .busy(busy0)
    );

    ram_blk_dp_ext #(
        .DATAWIDTH(32), .ADDRWIDTH(4), .BYTEWIDTH(8), .RDW_MODE(1),
        .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_addr(wr_addr),
        .we(we), .wr_be(wr_be), .rd_addr(rd_addr), .re(re),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic write_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        we = 1'b0; wr_be = 4'b0000;
    endtask

    task automatic read_one(input logic [3:0] a, output logic [31:0] d0, output logic v0,
                            output logic [31:0] d1, output logic v1);
        re = 1'b1; rd_addr = a;
        @(negedge clk);
        d0 = rd_data0; v0 = rd_valid0;
        re = 1'b0;
        @(negedge clk);
        d1 = rd_data1; v1 = rd_valid1;
    endtask

    // Releases reset and counts sampled busy cycles while hammering the user ports.
    task automatic run_clear(output int n0, output int n1, output int rv);
        n0 = 0; n1 = 0; rv = 0;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            if (rd_valid0 || rd_valid1) rv++;
            we = 1'b1; wr_addr = i[3:0]; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
            re = 1'b1; rd_addr = i[3:0];
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0; wr_be = 4'h0;
    endtask

    task automatic test_reset;
        int n0, n1, rv;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy: got %b/%b want 1/1", busy0, busy1);
        end
        n_checks++;
        if (rd_data0 !== 32'h0 || rd_valid0 !== 1'b0 || rd_data1 !== 32'h0 || rd_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %h/%b %h/%b want 0/0", rd_data0, rd_valid0, rd_data1, rd_valid1);
        end
        run_clear(n0, n1, rv);
        n_checks++;
        if (n0 != 16 || n1 != 16) begin
            n_fail++; $display("FAIL clear_busy_cycles: got %0d/%0d want 16", n0, n1);
        end
        n_checks++;
        if (rv != 0 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL read_while_busy: got %0d pulses, data %h/%h want 0", rv, rd_data0, rd_data1);
        end
    endtask

    task automatic test_clear_readback;
        logic [31:0] d0, d1;
        logic        v0, v1;
        int          bad;
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            read_one(a[3:0], d0, v0, d1, v1);
            n_checks++;
            if (d0 !== CV || v0 !== 1'b1 || d1 !== CV || v1 !== 1'b1) begin
                n_fail++; bad++;
                $display("FAIL clear_value addr %0d: got %h/%b %h/%b want %h/1", a, d0, v0, d1, v1, CV);
            end
        end
    endtask

    task automatic test_byte_enable;
        logic [31:0] d0, d1;
        logic        v0, v1;
        write_word(4'd3, 32'h11223344, 4'b1111);
        write_word(4'd3, 32'hAABBCCDD, 4'b0101);
        read_one(4'd3, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== 32'h11BB33DD || v0 !== 1'b1 || d1 !== 32'h11BB33DD || v1 !== 1'b1) begin
            n_fail++; $display("FAIL byte_enable: got %h/%b %h/%b want 11bb33dd/1", d0, v0, d1, v1);
        end
        // we with no lanes enabled must not write
        write_word(4'd3, 32'h00000000, 4'b0000);
        read_one(4'd3, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== 32'h11BB33DD || d1 !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL zero_be: got %h/%h want 11bb33dd", d0, d1);
        end
    endtask

    task automatic test_rdw;
        logic [31:0] d0, d1;
        logic        v0, v1;
        write_word(4'd5, 32'h00000000, 4'b1111);
        we = 1'b1; wr_addr = 4'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
        re = 1'b1; rd_addr = 4'd5;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wr_be = 4'b0000;
        n_checks++;
        if (rd_data0 !== 32'h00000000 || rd_valid0 !== 1'b1) begin
            n_fail++; $display("FAIL rdw_old: got %h/%b want 00000000/1", rd_data0, rd_valid0);
        end
        @(negedge clk);
        n_checks++;
        if (rd_data1 !== 32'h0000FFFF || rd_valid1 !== 1'b1) begin
            n_fail++; $display("FAIL rdw_new: got %h/%b want 0000ffff/1", rd_data1, rd_valid1);
        end
        read_one(4'd5, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== 32'h0000FFFF || d1 !== 32'h0000FFFF) begin
            n_fail++; $display("FAIL rdw_stored: got %h/%h want 0000ffff", d0, d1);
        end
        // Different addresses in the same cycle are independent
        we = 1'b1; wr_addr = 4'd6; wr_data = 32'h77777777; wr_be = 4'b1111;
        re = 1'b1; rd_addr = 4'd3;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wr_be = 4'b0000;
        d0 = rd_data0;
        @(negedge clk);
        n_checks++;
        if (d0 !== 32'h11BB33DD || rd_data1 !== 32'h11BB33DD) begin
            n_fail++; $display("FAIL diff_addr_read: got %h/%h want 11bb33dd", d0, rd_data1);
        end
        read_one(4'd6, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== 32'h77777777 || d1 !== 32'h77777777) begin
            n_fail++; $display("FAIL diff_addr_write: got %h/%h want 77777777", d0, d1);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [4];
        logic        exp_v0, exp_v1;
        for (int i = 0; i < 4; i++) begin
            vals[i] = 32'hB0B00000 + i;
            write_word(i[3:0], vals[i], 4'hF);
        end
        for (int k = 0; k < 6; k++) begin
            re = (k < 4); rd_addr = k[3:0];
            @(negedge clk);
            exp_v0 = (k < 4);
            exp_v1 = (k >= 1 && k <= 4);
            n_checks++;
            if (rd_valid0 !== exp_v0 || (exp_v0 && rd_data0 !== vals[k])) begin
                n_fail++; $display("FAIL b2b_lat1 step %0d: got %h/%b want valid %b", k, rd_data0, rd_valid0, exp_v0);
            end
            n_checks++;
            if (rd_valid1 !== exp_v1 || (exp_v1 && rd_data1 !== vals[k-1])) begin
                n_fail++; $display("FAIL b2b_lat2 step %0d: got %h/%b want valid %b", k, rd_data1, rd_valid1, exp_v1);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_hold;
        int p0, p1, bad;
        p0 = 0; p1 = 0; bad = 0;
        write_word(4'd2, 32'h12345678, 4'hF);
        for (int k = 0; k < 6; k++) begin
            re = (k == 0); rd_addr = 4'd2;
            @(negedge clk);
            if (rd_valid0) p0++;
            if (rd_valid1) p1++;
            if (rd_data0 !== 32'h12345678) bad++;
            if (k >= 1 && rd_data1 !== 32'h12345678) bad++;
        end
        n_checks++;
        if (p0 != 1 || p1 != 1) begin
            n_fail++; $display("FAIL hold_pulses: got %0d/%0d want 1/1", p0, p1);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hold_data: got %0d bad samples want 0", bad);
        end
    endtask

    task automatic test_reset_mid_clear;
        logic [31:0] d0, d1;
        logic        v0, v1;
        int          n0, n1, rv;
        re = 1'b1; rd_addr = 4'd3;
        @(posedge clk);
        #1;
        reset = 1'b1; re = 1'b0;
        #1;
        n_checks++;
        if (rd_data0 !== 32'h0 || rd_valid0 !== 1'b0 || rd_data1 !== 32'h0 || rd_valid1 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_outputs: got %h/%b %h/%b want 0/0", rd_data0, rd_valid0, rd_data1, rd_valid1);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (rd_valid1 !== 1'b0 || rd_data1 !== 32'h0) begin
            n_fail++; $display("FAIL dropped_read: got %h/%b want 0/0", rd_data1, rd_valid1);
        end
        reset = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL mid_clear_busy: got %b/%b want 1/1", busy0, busy1);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        run_clear(n0, n1, rv);
        n_checks++;
        if (n0 != 16 || n1 != 16 || rv != 0) begin
            n_fail++; $display("FAIL restart_clear: got %0d/%0d cycles %0d pulses want 16/16/0", n0, n1, rv);
        end
        read_one(4'd2, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== CV || d1 !== CV || v0 !== 1'b1 || v1 !== 1'b1) begin
            n_fail++; $display("FAIL refill_addr2: got %h/%h want %h", d0, d1, CV);
        end
        read_one(4'd15, d0, v0, d1, v1);
        n_checks++;
        if (d0 !== CV || d1 !== CV) begin
            n_fail++; $display("FAIL refill_addr15: got %h/%h want %h", d0, d1, CV);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; we = 1'b0; re = 1'b0;
        wr_data = '0; wr_addr = '0; wr_be = '0; rd_addr = '0;
        test_reset;
        test_clear_readback;
        test_byte_enable;
        test_rdw;
        test_back_to_back;
        test_hold;
        test_reset_mid_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
